// File: rtl/uart_rx_capture_pkg.sv
// Shared types for the UART receive capture slice.
// Frame state encoding and character width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_capture_if.sv
// Byte stream handshake from the UART receiver to its consumer.
// master drives data/valid, slave answers with ready.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO for received characters.
// Pointers carry one extra bit so full and empty are distinct.
module uart_rx_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_pop;
  logic         do_push;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the head slot for a push into a full FIFO
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_capture.sv
// UART receiver feeding a small FWFT FIFO; 8N1, or 8E1 when
// UART_RX_PARITY_EN is defined.
module uart_rx_capture
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 434,
  parameter  int FIFO_DEPTH   = 8,
  localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          rxd,
  uart_rx_if.master     rx,
  output logic [LW-1:0] fifo_level,
  output logic          frame_err,
  output logic          overrun,
  output logic          parity_err,
  input  logic          err_clr
);

  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

  logic                   sync1;
  logic                   sync2;
  logic                   prev;
  rx_state_e              state;
  logic [15:0]            cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shreg;
  logic                   fall;
  logic                   tick_half;
  logic                   tick_bit;
  logic                   commit;
  logic                   ferr_set;
  logic                   ovr_set;
  logic                   full;
  logic                   empty;

  assign fall      = prev && !sync2;
  assign tick_half = (cnt == HALF_END);
  assign tick_bit  = (cnt == BIT_END);
  assign commit    = (state == STOP) && tick_bit && sync2;
  assign ferr_set  = (state == STOP) && tick_bit && !sync2;
  assign ovr_set   = commit && full && !rx.rx_ready;

  // line idles high, so the synchroniser resets to 1
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (fall) state <= START;
        end
        START: begin
          if (tick_half) begin
            cnt   <= '0;
            state <= sync2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (tick_bit) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[UART_DATA_W-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        PARITY: begin
          if (tick_bit) begin
            cnt   <= '0;
            state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (tick_bit) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a new error wins over a clear in the same cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (err_clr)  frame_err <= 1'b0;
      if (ferr_set) frame_err <= 1'b1;
      if (err_clr)  overrun   <= 1'b0;
      if (ovr_set)  overrun   <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_set;

  assign par_set = (state == PARITY) && tick_bit && (sync2 != ^shreg);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      parity_err <= 1'b0;
    end else begin
      if (err_clr) parity_err <= 1'b0;
      if (par_set) parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (commit),
    .wdata  (shreg),
    .pop    (rx.rx_ready),
    .rdata  (rx.rx_data),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level)
  );

  assign rx.rx_valid = !empty;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture at 16 clocks per bit, depth 8.
// Parity case runs only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_capture;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       rxd = 1'b1;
  logic       err_clr = 1'b0;
  logic [3:0] fifo_level;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got [$];

  uart_rx_if rx_bus();

  always #5 clock = ~clock;

  uart_rx_capture #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .rxd        (rxd),
    .rx         (rx_bus),
    .fifo_level (fifo_level),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .err_clr    (err_clr)
  );

  always @(negedge clock)
    if (resetn && rx_bus.rx_valid && rx_bus.rx_ready)
      got.push_back(rx_bus.rx_data);

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] at(int i);
    return (i < got.size()) ? got[i] : 8'hxx;
  endfunction

  task automatic bits(int n);
    repeat (n * CPB) @(posedge clock);
    #1;
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
  endtask

  task automatic send(logic [7:0] b, logic stop);
    rxd = 1'b0;
    bits(1);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      bits(1);
    end
`ifdef UART_RX_PARITY_EN
    rxd = ^b;
    bits(1);
`endif
    rxd = stop;
    bits(1);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_bad_par(logic [7:0] b);
    rxd = 1'b0;
    bits(1);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      bits(1);
    end
    rxd = ~^b;
    bits(1);
    rxd = 1'b1;
    bits(1);
  endtask
`endif

  initial begin
    rx_bus.rx_ready = 1'b0;
    cyc(3);
    check("rst_valid", rx_bus.rx_valid, 0);
    check("rst_data", rx_bus.rx_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_flags", {frame_err, overrun, parity_err}, 0);
    resetn = 1'b1;
    rx_bus.rx_ready = 1'b1;
    bits(2);

    // back-to-back pair, consumer always ready
    got.delete();
    send(8'h55, 1'b1);
    send(8'hA3, 1'b1);
    bits(1);
    check("t1_count", got.size(), 2);
    check("t1_b0", at(0), 8'h55);
    check("t1_b1", at(1), 8'hA3);
    check("t1_flags", {frame_err, overrun, parity_err}, 0);

    // fill past depth with consumer stalled
    rx_bus.rx_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 9; i++) send(8'(i), 1'b1);
    bits(1);
    check("t2_level", fifo_level, 8);
    check("t2_overrun", overrun, 1);
    check("t2_valid", rx_bus.rx_valid, 1);
    check("t2_head", rx_bus.rx_data, 8'h00);
    rx_bus.rx_ready = 1'b1;
    bits(1);
    check("t2_count", got.size(), 8);
    for (int i = 0; i < 8; i++) check("t2_pop", at(i), 32'(i));
    check("t2_empty", fifo_level, 0);
    clr_pulse();
    check("t2_clr", overrun, 0);

    // bad stop bit, then line held low
    got.delete();
    send(8'h3C, 1'b0);
    bits(40);
    check("t3_ferr", frame_err, 1);
    check("t3_level", fifo_level, 0);
    check("t3_none", got.size(), 0);
    rxd = 1'b1;
    bits(2);
    send(8'h7E, 1'b1);
    bits(1);
    check("t3_count", got.size(), 1);
    check("t3_byte", at(0), 8'h7E);
    check("t3_sticky", frame_err, 1);
    clr_pulse();
    check("t3_clr", frame_err, 0);

    // short low glitch on idle line
    got.delete();
    rxd = 1'b0;
    cyc(4);
    rxd = 1'b1;
    bits(3);
    check("t4_none", got.size(), 0);
    check("t4_level", fifo_level, 0);
    check("t4_state", dut.state, 0);
    check("t4_flags", {frame_err, overrun, parity_err}, 0);

    // reset in the middle of a frame
    rx_bus.rx_ready = 1'b0;
    send(8'h11, 1'b1);
    bits(1);
    check("t5_pre", fifo_level, 1);
    rxd = 1'b0;
    bits(1);
    rxd = 1'b1;
    bits(3);
    resetn = 1'b0;
    #2;
    check("t5_valid", rx_bus.rx_valid, 0);
    check("t5_data", rx_bus.rx_data, 0);
    check("t5_level", fifo_level, 0);
    check("t5_flags", {frame_err, overrun, parity_err}, 0);
    cyc(2);
    resetn = 1'b1;
    bits(8);
    rx_bus.rx_ready = 1'b1;
    got.delete();
    send(8'h81, 1'b1);
    bits(1);
    check("t5_count", got.size(), 1);
    check("t5_byte", at(0), 8'h81);
    check("t5_ferr", frame_err, 0);

`ifdef UART_RX_PARITY_EN
    got.delete();
    send_bad_par(8'h07);
    bits(1);
    check("t6_perr", parity_err, 1);
    check("t6_byte", at(0), 8'h07);
    clr_pulse();
    send(8'h07, 1'b1);
    bits(1);
    check("t6_ok", parity_err, 0);
    check("t6_count", got.size(), 2);
`else
    check("t6_tied", parity_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
